// File: rtl/opb_sim2ppc_pkg.sv
// Shared definitions for the Simulink-to-PPC OPB register block:
// register word offsets, STATUS/CTRL bit positions and the slave FSM states.
package opb_sim2ppc_pkg;

    // Word indices taken from OPB_ABus[28:29]
    localparam logic [1:0] REG_DATA   = 2'd0;   // 0x0
    localparam logic [1:0] REG_STATUS = 2'd1;   // 0x4
    localparam logic [1:0] REG_CTRL   = 2'd2;   // 0x8
    localparam logic [1:0] REG_RSVD   = 2'd3;   // 0xC

    // STATUS bit positions (user numbering)
    localparam int unsigned STATUS_NEW_BIT = 31;
    localparam int unsigned STATUS_OVF_BIT = 30;

    // CTRL bit positions (user numbering)
    localparam int unsigned CTRL_FREEZE_BIT  = 0;
    localparam int unsigned CTRL_CNT_CLR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } opb_state_e;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and single-cycle acknowledge FSM for a small OPB slave.
// Latches the word index on a hit so the register side sees a stable index
// during the acknowledge cycle.
module opb_slave_ack_fsm
    import opb_sim2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B2500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B25FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic                    select,
    output logic                    xfer_ack,
    output logic [1:0]              word_idx
);

    opb_state_e state;
    opb_state_e state_nxt;
    logic       hit;

    assign hit      = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign xfer_ack = (state == ST_ACK);

    // State register and word-index latch taken when a hit is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && hit) begin
                word_idx <= abus[28:29];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hit)     state_nxt = ST_ACK;
            ST_ACK:               state_nxt = ST_WAIT;
            ST_WAIT: if (!select) state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave register passing a captured user value to the PowerPC.
// Registers: DATA (RO), STATUS (RO), CTRL (RW, bit0 freeze), reserved.
// Optional update counter in STATUS[15:0]: define OPB_SIM2PPC_UPDATE_CNT_EN.
module opb_register_simulink2ppc
    import opb_sim2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B2500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B25FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid,
    output logic                    user_frozen
);

    logic        xfer_ack;
    logic [1:0]  word_idx;
    logic [31:0] data_reg;
    logic        new_flag;
    logic        ovf_flag;
    logic        freeze;
    logic        capture;
    logic        rd_data_clr;
    logic        rd_stat_clr;
    logic        ctrl_wr;
    logic [31:0] status_word;
    logic [31:0] rdata;
    logic        unused_inputs;

    opb_slave_ack_fsm #(
        .C_BASEADDR  (C_BASEADDR),
        .C_HIGHADDR  (C_HIGHADDR),
        .C_OPB_AWIDTH(C_OPB_AWIDTH)
    ) u_ack_fsm (
        .clk     (OPB_Clk),
        .rst_n   (OPB_Rst_n),
        .abus    (OPB_ABus),
        .select  (OPB_select),
        .xfer_ack(xfer_ack),
        .word_idx(word_idx)
    );

    assign capture     = user_data_valid && !freeze;
    assign rd_data_clr = xfer_ack && OPB_RNW && (word_idx == REG_DATA);
    assign rd_stat_clr = xfer_ack && OPB_RNW && (word_idx == REG_STATUS);
    // Only the low byte (OPB bits 24..31) carries CTRL bits, so BE[3] gates it
    assign ctrl_wr     = xfer_ack && !OPB_RNW && (word_idx == REG_CTRL) && OPB_BE[3];

    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus};

    // Capture path and flag handling; a capture wins over a clearing read
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_reg <= '0;
            new_flag <= 1'b0;
            ovf_flag <= 1'b0;
            freeze   <= 1'b0;
        end else begin
            if (capture) begin
                data_reg <= user_data_in;
                new_flag <= 1'b1;
                if (new_flag) ovf_flag <= 1'b1;
            end else begin
                if (rd_data_clr) new_flag <= 1'b0;
                if (rd_stat_clr) ovf_flag <= 1'b0;
            end
            if (ctrl_wr) freeze <= OPB_DBus[31-CTRL_FREEZE_BIT];
        end
    end

`ifdef OPB_SIM2PPC_UPDATE_CNT_EN
    logic [15:0] upd_cnt;
    logic        cnt_clr;

    assign cnt_clr = ctrl_wr && OPB_DBus[31-CTRL_CNT_CLR_BIT];

    // Wrapping count of accepted captures, cleared by CTRL bit1
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            upd_cnt <= '0;
        end else if (cnt_clr) begin
            upd_cnt <= '0;
        end else if (capture) begin
            upd_cnt <= upd_cnt + 16'd1;
        end
    end
`endif

    // Read-data mux; OPB bit i equals user bit 31-i via the vector assignment
    always_comb begin
        status_word                 = '0;
        status_word[STATUS_NEW_BIT] = new_flag;
        status_word[STATUS_OVF_BIT] = ovf_flag;
`ifdef OPB_SIM2PPC_UPDATE_CNT_EN
        status_word[15:0]           = upd_cnt;
`endif
        rdata = '0;
        case (word_idx)
            REG_DATA:   rdata = data_reg;
            REG_STATUS: rdata = status_word;
            REG_CTRL:   rdata[CTRL_FREEZE_BIT] = freeze;
            default:    rdata = '0;
        endcase
    end

    assign Sl_DBus     = (xfer_ack && OPB_RNW) ? rdata : '0;
    assign Sl_xferAck  = xfer_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = freeze;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench for opb_register_simulink2ppc.
// Transaction-level model of the registers; a negedge process compares the
// slave outputs to the model every cycle, directed steps pin literal values.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h010B2500;
    localparam logic [31:0] HIGH = 32'h010B25FF;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst_n = 1'b1;
    logic [0:31] OPB_ABus = '0;
    logic [0:3]  OPB_BE = '0;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_RNW = 1'b0;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in = '0;
    logic        user_data_valid = 1'b0;
    logic        user_frozen;

    int total = 0;
    int bad = 0;

    // Model state
    logic [31:0] m_data = '0;
    logic        m_new = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_frozen = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        exp_ack = 1'b0;
    logic [31:0] exp_dbus = '0;
    logic        chk_en = 1'b0;
    logic [31:0] got;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_register_simulink2ppc #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32)
    ) dut (
        .OPB_Clk        (OPB_Clk),
        .OPB_Rst_n      (OPB_Rst_n),
        .OPB_ABus       (OPB_ABus),
        .OPB_BE         (OPB_BE),
        .OPB_DBus       (OPB_DBus),
        .OPB_RNW        (OPB_RNW),
        .OPB_select     (OPB_select),
        .OPB_seqAddr    (OPB_seqAddr),
        .Sl_DBus        (Sl_DBus),
        .Sl_xferAck     (Sl_xferAck),
        .Sl_errAck      (Sl_errAck),
        .Sl_retry       (Sl_retry),
        .Sl_toutSup     (Sl_toutSup),
        .user_data_in   (user_data_in),
        .user_data_valid(user_data_valid),
        .user_frozen    (user_frozen)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] idx);
        logic [31:0] v;
        v = '0;
        case (idx)
            2'd0: v = m_data;
            2'd1: begin
                v[31]   = m_new;
                v[30]   = m_ovf;
                v[15:0] = m_cnt;
            end
            2'd2: v[0] = m_frozen;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_data = '0; m_new = 1'b0; m_ovf = 1'b0; m_frozen = 1'b0; m_cnt = '0;
        exp_ack = 1'b0; exp_dbus = '0;
    endtask

    task automatic model_capture(input logic [31:0] v);
        if (!m_frozen) begin
            if (m_new) m_ovf = 1'b1;
            m_new  = 1'b1;
            m_data = v;
`ifdef OPB_SIM2PPC_UPDATE_CNT_EN
            m_cnt  = m_cnt + 16'd1;
`endif
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge OPB_Clk) begin
        if (chk_en) begin
            check("xferack", {31'b0, Sl_xferAck}, {31'b0, exp_ack});
            check("sl_dbus", Sl_DBus, exp_dbus);
            check("frozen", {31'b0, user_frozen}, {31'b0, m_frozen});
            check("tieoffs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
        end
    end

    task automatic capture(input logic [31:0] v);
        user_data_in = v;
        user_data_valid = 1'b1;
        @(posedge OPB_Clk); #2;
        user_data_valid = 1'b0;
        model_capture(v);
    endtask

    // One OPB transfer; optional user capture sampled on the edge ending the ack cycle
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                        input logic [0:3] be, input logic cap_in_ack, input logic [31:0] cap_val,
                        output logic [31:0] rd);
        logic       hit;
        logic [1:0] idx;
        logic       cap_ok;
        hit = (addr >= BASE) && (addr <= HIGH);
        idx = addr[3:2];
        OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be;
        OPB_DBus = rnw ? 32'h0 : wdata;
        OPB_select = 1'b1;
        @(posedge OPB_Clk); #2;
        if (hit) begin
            exp_ack  = 1'b1;
            exp_dbus = rnw ? m_read(idx) : 32'h0;
        end
        if (cap_in_ack) begin
            user_data_in = cap_val;
            user_data_valid = 1'b1;
        end
        #1 rd = Sl_DBus;
        @(posedge OPB_Clk); #2;
        exp_ack = 1'b0; exp_dbus = '0;
        OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0; OPB_DBus = '0;
        user_data_valid = 1'b0;
        cap_ok = cap_in_ack && !m_frozen;
        if (hit) begin
            if (rnw && idx == 2'd0 && !cap_ok) m_new = 1'b0;
            if (rnw && idx == 2'd1 && !cap_ok) m_ovf = 1'b0;
            if (!rnw && idx == 2'd2 && be[3]) begin
                m_frozen = wdata[0];
`ifdef OPB_SIM2PPC_UPDATE_CNT_EN
                if (wdata[1]) m_cnt = '0;
`endif
            end
        end
        if (cap_in_ack) model_capture(cap_val);
        @(posedge OPB_Clk); #2;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] v);
        xfer(BASE + off, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0, v);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] v, input logic [0:3] be);
        logic [31:0] dummy;
        xfer(BASE + off, 1'b0, v, be, 1'b0, 32'h0, dummy);
    endtask

    initial begin
        // Reset
        #1 OPB_Rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
        check("rst_dbus", Sl_DBus, 32'h0);
        check("rst_frozen", {31'b0, user_frozen}, 32'h0);
        repeat (2) @(posedge OPB_Clk);
        #2 OPB_Rst_n = 1'b1;
        @(posedge OPB_Clk); #2;

        rd(32'h0, got); check("rst_data", got, 32'h0);
        rd(32'h4, got); check("rst_status", got, 32'h0);
        rd(32'h8, got); check("rst_ctrl", got, 32'h0);

        // Capture then read DATA, STATUS new cleared
        capture(32'hDEADBEEF);
        rd(32'h0, got); check("data_deadbeef", got, 32'hDEADBEEF);
        rd(32'h4, got); check("status_new_clr", {31'b0, got[31]}, 32'h0);

        // Two captures -> overflow; STATUS read clears overflow only
        capture(32'h00000001);
        capture(32'h00000002);
        rd(32'h4, got);
        check("ovf_new", {31'b0, got[31]}, 32'h1);
        check("ovf_set", {31'b0, got[30]}, 32'h1);
        rd(32'h4, got);
        check("ovf_clr", {31'b0, got[30]}, 32'h0);
        check("ovf_new_kept", {31'b0, got[31]}, 32'h1);
        rd(32'h0, got); check("data_second", got, 32'h00000002);

        // Freeze drops captures
        wr(32'h8, 32'h1, 4'b1111);
        check("frozen_set", {31'b0, user_frozen}, 32'h1);
        capture(32'h12345678);
        rd(32'h0, got); check("frozen_data", got, 32'h00000002);
        rd(32'h4, got); check("frozen_new", {31'b0, got[31]}, 32'h0);
        wr(32'h8, 32'h0, 4'b1111);
        check("frozen_clr", {31'b0, user_frozen}, 32'h0);
        capture(32'h12345678);
        rd(32'h0, got); check("unfrozen_data", got, 32'h12345678);

        // BE[3] low: CTRL write ignored
        wr(32'h8, 32'h1, 4'b1110);
        check("be_gated", {31'b0, user_frozen}, 32'h0);

        // Capture on the edge of a DATA read
        capture(32'hAAAA5555);
        xfer(BASE, 1'b1, 32'h0, 4'b1111, 1'b1, 32'h5555AAAA, got);
        check("race_old", got, 32'hAAAA5555);
        rd(32'h4, got);
        check("race_new", {31'b0, got[31]}, 32'h1);
        check("race_ovf", {31'b0, got[30]}, 32'h1);
        rd(32'h0, got); check("race_data", got, 32'h5555AAAA);

        // Reserved word
        wr(32'hC, 32'hFFFFFFFF, 4'b1111);
        rd(32'hC, got); check("rsvd", got, 32'h0);
        rd(32'h8, got); check("ctrl_after_rsvd", got, 32'h0);

        // Out-of-window selects
        xfer(HIGH + 32'h4, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0, got);
        check("oow_high", got, 32'h0);
        xfer(BASE - 32'h4, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0, got);
        check("oow_low", got, 32'h0);

`ifdef OPB_SIM2PPC_UPDATE_CNT_EN
        wr(32'h8, 32'h2, 4'b1111);
        rd(32'h4, got); check("cnt_clr", {16'b0, got[15:0]}, 32'h0);
        user_data_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            user_data_in = i;
            @(posedge OPB_Clk); #2;
            model_capture(i);
        end
        user_data_valid = 1'b0;
        rd(32'h4, got); check("cnt_wrap", {16'b0, got[15:0]}, 32'h1);
`endif

        // Reset during the ack cycle
        wr(32'h8, 32'h1, 4'b1111);
        OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
        @(posedge OPB_Clk); #2;
        exp_ack = 1'b1; exp_dbus = m_read(2'd0);
        #1 OPB_Rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_in_ack", {31'b0, Sl_xferAck}, 32'h0);
        check("rst_in_ack_dbus", Sl_DBus, 32'h0);
        check("rst_in_ack_frozen", {31'b0, user_frozen}, 32'h0);
        OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0;
        @(posedge OPB_Clk); #2;
        OPB_Rst_n = 1'b1;
        @(posedge OPB_Clk); #2;
        rd(32'h0, got); check("post_rst_data", got, 32'h0);
        rd(32'h4, got); check("post_rst_status", got, 32'h0);

        repeat (2) @(posedge OPB_Clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h010B2500, first byte of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010B25FF, last byte of the slave window.
REQ-003 SHALL have parameters C_OPB_AWIDTH and C_OPB_DWIDTH, each default 32, giving the OPB address and data widths.
REQ-004 SHALL have port OPB_Clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port OPB_Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports OPB_ABus[0:31], OPB_BE[0:3], OPB_DBus[0:31], OPB_RNW, OPB_select and OPB_seqAddr, all inputs: the OPB master request.
REQ-007 SHALL have ports Sl_DBus[0:31], Sl_xferAck, Sl_errAck, Sl_retry and Sl_toutSup, all outputs: the slave response.
REQ-008 SHALL have port user_data_in[31:0], input: the value from the user logic.
REQ-009 SHALL have port user_data_valid, input, 1 bit: single-cycle capture strobe for user_data_in.
REQ-010 SHALL have port user_frozen, output, 1 bit: mirrors CTRL.freeze.

Function
REQ-011 SHALL map OPB bit i to user bit 31-i on every data path.
REQ-012 SHALL decode a hit when OPB_select=1 and C_BASEADDR<=OPB_ABus<=C_HIGHADDR; word index = OPB_ABus[28:29].
REQ-013 SHALL use register map 0x0 DATA (RO), 0x4 STATUS (RO), 0x8 CTRL (RW, bit0 freeze), 0xC reserved (reads 0, writes ignored).
REQ-014 SHALL use FSM IDLE->ACK on a hit, ACK->WAIT unconditionally, WAIT->IDLE when OPB_select=0.
REQ-015 SHALL assert Sl_xferAck exactly one cycle (state ACK), i.e. one cycle after the hit is sampled.
REQ-016 SHALL drive Sl_DBus with read data only while Sl_xferAck=1 and OPB_RNW=1, else all zeros (OR-bus).
REQ-017 SHALL tie Sl_errAck, Sl_retry and Sl_toutSup to 0.
REQ-018 SHALL accept a CTRL write in ACK with byte enables honoured; OPB_BE[3] gates bit0.
REQ-019 SHALL, on user_data_valid=1 with freeze=0, load DATA and set STATUS.new on the next edge.
REQ-020 SHALL set STATUS.overflow if a capture occurs while new=1.
REQ-021 SHALL drop a strobe while freeze=1, with DATA, new and overflow unchanged.
REQ-022 SHALL clear new on a DATA read in ACK and clear overflow on a STATUS read in ACK.
REQ-023 SHALL give capture priority when a capture and a clearing read share an edge: the read returns the old value and the flag stays set.
REQ-024 SHALL use STATUS layout bit31 new, bit30 overflow, bits15:0 update count (REQ-029), all other bits 0.

Reset
REQ-025 SHALL, on OPB_Rst_n=0, immediately return the FSM to IDLE and force Sl_xferAck=0, Sl_DBus=0, DATA=0, STATUS=0, CTRL=0 and user_frozen=0.
REQ-026 SHALL abandon an in-flight transfer on reset without ack; the master times out.
REQ-027 SHALL release reset on the clock edge only, with no action on the first post-reset edge except a new hit.

Configuration
REQ-028 SHALL compile in the update counter when macro OPB_SIM2PPC_UPDATE_CNT_EN is defined.
REQ-029 SHALL, with the macro defined, increment STATUS[15:0] on each accepted capture, wrap from 0xFFFF to 0x0000, and clear it by writing 1 to CTRL bit1.
REQ-030 SHALL, without the macro, read STATUS[15:0] as 0, ignore CTRL bit1 and synthesise no counter flops.

Structure
REQ-031 SHALL place the register offsets, the STATUS/CTRL bit positions and the FSM state enum in shared package opb_sim2ppc_pkg.
REQ-032 SHALL implement address decode plus FSM as sub-module opb_slave_ack_fsm, reusable by sibling OPB registers; the top holds the registers.

Verification
REQ-033 SHALL cover: capture 0xDEADBEEF, then read 0x0 -> Sl_DBus=0xDEADBEEF on the ack cycle, and a following STATUS read has bit31=0.
REQ-034 SHALL cover: two captures before any read -> STATUS bit31=1 and bit30=1; a second STATUS read shows bit30=0.
REQ-035 SHALL cover: write CTRL=1, capture 0x12345678 -> DATA unchanged and user_frozen=1; write CTRL=0 -> the next capture is taken.
REQ-036 SHALL cover: capture on the same edge as a DATA read -> the read returns the old value and new stays 1.
REQ-037 SHALL cover: out-of-window select at C_HIGHADDR+4 -> no Sl_xferAck and Sl_DBus=0.
REQ-038 SHALL cover: assert OPB_Rst_n=0 in state ACK -> Sl_xferAck drops at once; with the macro defined, 65537 captures -> count=1.
